video_daisy_ctrl_sequencer: RTL and testbench

//  Parametrised per-core control writer for the video daisy-chain system, in the sys_clk domain.

---
 rtl/video_daisy_pkg.sv | 9 +
 rtl/video_daisy_ctrl_sequencer_key_debounce.sv | 53 +++++
 rtl/video_daisy_ctrl_sequencer.sv | 125 ++++++++++++
 tb/tb_video_daisy_ctrl_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_daisy_pkg.sv
// Shared types and constants for the video daisy-chain control blocks.
package video_daisy_pkg;

    typedef enum logic {IDLE, WRITE} ctrl_seq_state_t;

    localparam int CTRL_REG_ADDR    = 0;
    localparam int DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/video_daisy_ctrl_sequencer_key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, level debounce and a one-cycle press pulse
// on the debounced high-to-low transition of the active-low key.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_p0;
    logic             key_p1;
    logic             deb_key;
    logic             deb_key_p2;
    logic [CNT_W-1:0] cnt;

    // synchroniser stages idle at the released level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
        end else begin
            key_p0 <= key_n;
            key_p1 <= key_p0;
        end
    end

    // debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_key    <= 1'b1;
            deb_key_p2 <= 1'b1;
            cnt        <= '0;
        end else begin
            deb_key_p2 <= deb_key;
            if (key_p1 == deb_key) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb_key <= key_p1;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = deb_key_p2 & ~deb_key;

endmodule

// File: rtl/video_daisy_ctrl_sequencer.sv
// Per-core control writer: on a key press (or, optionally, a switch change) it snapshots the
// switches and writes one bit to each core's Avalon-MM control register in turn.
module video_daisy_ctrl_sequencer
    import video_daisy_pkg::*;
#(
    parameter int NUM_CORES       = 4,
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int AUTO_UPDATE     = 0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 key_n,
    input  logic [NUM_CORES-1:0] sw,
    input  logic [NUM_CORES-1:0] avs_waitrequest,
    output logic [NUM_CORES-1:0] avs_write,
    output logic [ADDR_W-1:0]    avs_address,
    output logic [DATA_W-1:0]    avs_writedata,
    output logic                 busy,
    output logic [NUM_CORES-1:0] status
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CORES - 1);

    function automatic logic [DATA_W-1:0] ctrl_word(input logic bit0);
        return DATA_W'(bit0);
    endfunction

    logic [NUM_CORES-1:0] sw_p0;
    logic [NUM_CORES-1:0] sw_p1;
    logic [NUM_CORES-1:0] snapshot;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nxt;
    ctrl_seq_state_t      state;
    logic                 pending;
    logic                 press;
    logic                 auto_trig;
    logic                 trigger;
    logic                 accept;
    logic                 last;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .key_n (key_n),
        .press (press)
    );

    // switch synchroniser
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sw_p0 <= '0;
            sw_p1 <= '0;
        end else begin
            sw_p0 <= sw;
            sw_p1 <= sw_p0;
        end
    end

    assign auto_trig = (AUTO_UPDATE != 0) && (sw_p1 != status) && !busy;
    assign trigger   = press | pending | auto_trig;
    assign idx_nxt   = idx + 1'b1;
    assign accept    = avs_write[idx] & ~avs_waitrequest[idx];
    assign last      = (idx == IDX_LAST);

    // sequencer FSM; every output holds its value while the addressed core stalls
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            pending       <= 1'b0;
            snapshot      <= '0;
            idx           <= '0;
            status        <= '0;
            avs_write     <= '0;
            avs_address   <= '0;
            avs_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy      <= 1'b0;
                    avs_write <= '0;
                    if (trigger) begin
                        state         <= WRITE;
                        busy          <= 1'b1;
                        pending       <= 1'b0;
                        snapshot      <= sw_p1;
                        idx           <= '0;
                        avs_write     <= NUM_CORES'(1);
                        avs_address   <= ADDR_W'(CTRL_REG_ADDR);
                        avs_writedata <= ctrl_word(sw_p1[0]);
                    end
                end
                WRITE: begin
                    if (press) begin
                        pending <= 1'b1;
                    end
                    if (accept) begin
                        status[idx] <= snapshot[idx];
                        if (last) begin
                            state         <= IDLE;
                            busy          <= 1'b0;
                            avs_write     <= '0;
                            avs_writedata <= '0;
                        end else begin
                            idx           <= idx_nxt;
                            avs_write     <= avs_write << 1;
                            avs_writedata <= ctrl_word(snapshot[idx_nxt]);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    avs_write <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_daisy_ctrl_sequencer.sv
// Directed bench for the control sequencer: one key-driven instance and one AUTO_UPDATE instance.
module tb_video_daisy_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_n;
    logic [3:0]  sw;
    logic [3:0]  wr;
    logic [3:0]  w;
    logic [0:0]  addr;
    logic [31:0] wd;
    logic        busy;
    logic [3:0]  status;

    logic        rst2;
    logic        key2_n;
    logic [3:0]  sw2;
    logic [3:0]  wr2;
    logic [3:0]  w2;
    logic [0:0]  addr2;
    logic [31:0] wd2;
    logic        busy2;
    logic [3:0]  status2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    video_daisy_ctrl_sequencer #(
        .NUM_CORES(4), .DATA_W(32), .ADDR_W(1), .DEBOUNCE_CYCLES(4), .AUTO_UPDATE(0)
    ) dut (
        .sys_clk(clk), .sys_rst(rst), .key_n(key_n), .sw(sw), .avs_waitrequest(wr),
        .avs_write(w), .avs_address(addr), .avs_writedata(wd), .busy(busy), .status(status)
    );

    video_daisy_ctrl_sequencer #(
        .NUM_CORES(4), .DATA_W(32), .ADDR_W(1), .DEBOUNCE_CYCLES(4), .AUTO_UPDATE(1)
    ) dut_au (
        .sys_clk(clk), .sys_rst(rst2), .key_n(key2_n), .sw(sw2), .avs_waitrequest(wr2),
        .avs_write(w2), .avs_address(addr2), .avs_writedata(wd2), .busy(busy2), .status(status2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_write(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            tick();
            if (w != 4'b0000) seen = 1'b1;
        end
    endtask

    task automatic wait_write2(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            tick();
            if (w2 != 4'b0000) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;
        int extra;
        rst = 1'b1; key_n = 1'b1; sw = 4'b0000; wr = 4'b0000;
        rst2 = 1'b1; key2_n = 1'b1; sw2 = 4'b0000; wr2 = 4'b0000;
        repeat (3) tick();
        rst = 1'b0; rst2 = 1'b0;

        // 1: reset state and quiet idle
        chk("rst_write", {28'd0, w}, 32'd0);
        chk("rst_wdata", wd, 32'd0);
        chk("rst_addr", {31'd0, addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_status", {28'd0, status}, 32'd0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (w != 0 || busy) extra++;
        end
        chk("idle_quiet", extra, 0);

        // 2: glitch shorter than the debounce window
        key_n = 1'b0;
        repeat (3) tick();
        key_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (w != 0 || busy) extra++;
        end
        chk("glitch_ignored", extra, 0);

        // 3: held key, no stalls
        sw = 4'b1010;
        key_n = 1'b0;
        wait_write(seen);
        chk("t3_started", {31'd0, seen}, 32'd1);
        chk("t3_w0", {28'd0, w}, 32'h1);
        chk("t3_d0", wd, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        tick(); chk("t3_w1", {28'd0, w}, 32'h2); chk("t3_d1", wd, 32'd1);
        tick(); chk("t3_w2", {28'd0, w}, 32'h4); chk("t3_d2", wd, 32'd0);
        tick(); chk("t3_w3", {28'd0, w}, 32'h8); chk("t3_d3", wd, 32'd1);
        tick(); chk("t3_done_w", {28'd0, w}, 32'h0);
        chk("t3_done_busy", {31'd0, busy}, 32'd0);
        chk("t3_status", {28'd0, status}, 32'ha);
        extra = 0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (w != 0) extra++;
        end
        key_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (w != 0) extra++;
        end
        chk("t3_single_seq", extra, 0);

        // 4: core 1 stalls for 5 cycles
        key_n = 1'b0;
        wait_write(seen);
        chk("t4_started", {31'd0, seen}, 32'd1);
        wr = 4'b0010;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (w !== 4'b0010 || wd !== 32'd1) extra++;
        end
        chk("t4_held_6", extra, 0);
        wr = 4'b0000;
        tick(); chk("t4_next_w", {28'd0, w}, 32'h4); chk("t4_next_d", wd, 32'd0);
        key_n = 1'b1;
        repeat (20) tick();

        // 5: presses during a stalled sequence give exactly one follow-up sequence
        sw = 4'b0011;
        key_n = 1'b0;
        wait_write(seen);
        chk("t5_started", {31'd0, seen}, 32'd1);
        chk("t5_d0", wd, 32'd1);
        wr = 4'b0001;
        for (int i = 0; i < 50; i++) begin
            if (i == 25) sw = 4'b0101;
            key_n = ((i / 10) % 2 == 0) ? 1'b1 : 1'b0;
            tick();
        end
        key_n = 1'b1;
        chk("t5_stalled_w", {28'd0, w}, 32'h1);
        wr = 4'b0000;
        tick(); chk("t5_a_w1", {28'd0, w}, 32'h2); chk("t5_a_d1", wd, 32'd1);
        tick(); chk("t5_a_w2", {28'd0, w}, 32'h4); chk("t5_a_d2", wd, 32'd0);
        tick(); chk("t5_a_w3", {28'd0, w}, 32'h8); chk("t5_a_d3", wd, 32'd0);
        tick(); chk("t5_gap_w", {28'd0, w}, 32'h0); chk("t5_gap_busy", {31'd0, busy}, 32'd0);
        chk("t5_mid_status", {28'd0, status}, 32'h3);
        tick(); chk("t5_b_w0", {28'd0, w}, 32'h1); chk("t5_b_d0", wd, 32'd1);
        tick(); chk("t5_b_w1", {28'd0, w}, 32'h2); chk("t5_b_d1", wd, 32'd0);
        tick(); chk("t5_b_w2", {28'd0, w}, 32'h4); chk("t5_b_d2", wd, 32'd1);
        tick(); chk("t5_b_w3", {28'd0, w}, 32'h8); chk("t5_b_d3", wd, 32'd0);
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (w != 0) extra++;
        end
        chk("t5_no_third", extra, 0);
        chk("t5_status", {28'd0, status}, 32'h5);

        // 6: AUTO_UPDATE instance follows a switch change, then reset mid-sequence
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (w2 != 0) extra++;
        end
        chk("t6_quiet", extra, 0);
        sw2 = 4'b0100;
        wait_write2(seen);
        chk("t6_started", {31'd0, seen}, 32'd1);
        chk("t6_w0", {28'd0, w2}, 32'h1); chk("t6_d0", wd2, 32'd0);
        tick(); chk("t6_w1", {28'd0, w2}, 32'h2); chk("t6_d1", wd2, 32'd0);
        tick(); chk("t6_w2", {28'd0, w2}, 32'h4); chk("t6_d2", wd2, 32'd1);
        tick(); chk("t6_w3", {28'd0, w2}, 32'h8); chk("t6_d3", wd2, 32'd0);
        tick(); chk("t6_done", {28'd0, w2}, 32'h0);
        chk("t6_status", {28'd0, status2}, 32'h4);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (w2 != 0) extra++;
        end
        chk("t6_one_seq", extra, 0);
        sw2 = 4'b0000;
        wait_write2(seen);
        chk("t6r_started", {31'd0, seen}, 32'd1);
        tick(); chk("t6r_core1", {28'd0, w2}, 32'h2);
        rst2 = 1'b1;
        #1;
        chk("t6r_write", {28'd0, w2}, 32'h0);
        chk("t6r_status", {28'd0, status2}, 32'h0);
        chk("t6r_busy", {31'd0, busy2}, 32'd0);
        tick();
        rst2 = 1'b0;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (w2 != 0) extra++;
        end
        chk("t6r_quiet", extra, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
